// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path:
// opcodes, funct codes, ALU control codes, FSM states and ALU ops.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_ALUWB,
        S_BEQ,
        S_BNE,
        S_ADDIEX,
        S_LOGIEX,
        S_IMMWB,
        S_JUMP,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT,
        ALUOP_AND,
        ALUOP_OR
    } aluop_e;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps (aluop, funct) to an ALU control code.
// Ports: aluop, funct in; alucontrol (zero-extended), illegal_funct out.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  aluop_e               aluop,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal_funct
);

    logic [2:0] code;

    always_comb begin
        code          = ALUC_ADD;
        illegal_funct = 1'b0;
        case (aluop)
            ALUOP_ADD: code = ALUC_ADD;
            ALUOP_SUB: code = ALUC_SUB;
            ALUOP_AND: code = ALUC_AND;
            ALUOP_OR:  code = ALUC_OR;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   code = ALUC_ADD;
                    F_SUB:   code = ALUC_SUB;
                    F_AND:   code = ALUC_AND;
                    F_OR:    code = ALUC_OR;
                    F_SLT:   code = ALUC_SLT;
                    default: illegal_funct = 1'b1;
                endcase
            end
            default: code = ALUC_ADD;
        endcase
    end

    assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback
// sequencing with a mem_ready stall and a sticky illegal-op trap.
// Ports: clk, reset_n, op, funct, zero, mem_ready in; datapath
// enables/mux selects, alucontrol and trap out.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit HAS_BNE   = 1'b1,
    parameter bit HAS_LOGI  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pcen,
    output logic                 iord,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 trap
);

    state_e state_q, state_d;
    logic   trap_q, trap_d;
    aluop_e aluop;
    logic   illegal_funct;

    alu_decoder #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_alu_decoder (
        .aluop        (aluop),
        .funct        (funct),
        .alucontrol   (alucontrol),
        .illegal_funct(illegal_funct)
    );

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        case (state_q)
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                // Anything not claimed below is an illegal opcode.
                state_d = S_HALT;
                trap_d  = 1'b1;
                case (op)
                    OP_LW, OP_SW: begin
                        state_d = S_MEMADR;
                        trap_d  = trap_q;
                    end
                    OP_RTYPE: begin
                        state_d = S_RTYPEEX;
                        trap_d  = trap_q;
                    end
                    OP_BEQ: begin
                        state_d = S_BEQ;
                        trap_d  = trap_q;
                    end
                    OP_BNE: begin
                        if (HAS_BNE) begin
                            state_d = S_BNE;
                            trap_d  = trap_q;
                        end
                    end
                    OP_ADDI: begin
                        state_d = S_ADDIEX;
                        trap_d  = trap_q;
                    end
                    OP_ANDI, OP_ORI: begin
                        if (HAS_LOGI) begin
                            state_d = S_LOGIEX;
                            trap_d  = trap_q;
                        end
                    end
                    OP_J: begin
                        state_d = S_JUMP;
                        trap_d  = trap_q;
                    end
                    default: ;
                endcase
            end
            S_MEMADR:
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: if (mem_ready) state_d = S_FETCH;
            S_RTYPEEX: begin
                if (illegal_funct) begin
                    state_d = S_HALT;
                    trap_d  = 1'b1;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ADDIEX, S_LOGIEX: state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_IMMWB,
            S_BEQ, S_BNE, S_JUMP: state_d = S_FETCH;
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
        end
    end

    // Moore decode; only pcen/irwrite also look at zero/mem_ready.
    always_comb begin
        pcen     = 1'b0;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQ: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                pcen    = zero;
            end
            S_BNE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                pcen    = ~zero;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_LOGIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b11;
                aluop   = (op == OP_ORI) ? ALUOP_OR : ALUOP_AND;
            end
            S_IMMWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
    end

    assign trap = trap_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected
// output words queued by the driver and compared by a checker.
module tb_multicycle_controller;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pcen, iord, memread, memwrite, irwrite;
    logic       regdst, memtoreg, regwrite, alusrca, trap;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    logic       nb_pcen, nb_iord, nb_memread, nb_memwrite, nb_irwrite;
    logic       nb_regdst, nb_memtoreg, nb_regwrite, nb_alusrca, nb_trap;
    logic [1:0] nb_alusrcb, nb_pcsrc;
    logic [2:0] nb_alucontrol;

    multicycle_controller u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pcen      (pcen),
        .iord      (iord),
        .memread   (memread),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .alucontrol(alucontrol),
        .trap      (trap)
    );

    multicycle_controller #(
        .HAS_BNE(1'b0)
    ) u_nb (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pcen      (nb_pcen),
        .iord      (nb_iord),
        .memread   (nb_memread),
        .memwrite  (nb_memwrite),
        .irwrite   (nb_irwrite),
        .regdst    (nb_regdst),
        .memtoreg  (nb_memtoreg),
        .regwrite  (nb_regwrite),
        .alusrca   (nb_alusrca),
        .alusrcb   (nb_alusrcb),
        .pcsrc     (nb_pcsrc),
        .alucontrol(nb_alucontrol),
        .trap      (nb_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // [16] trap [15] pcen [14] iord [13] memread [12] memwrite
    // [11] irwrite [10] regdst [9] memtoreg [8] regwrite
    // [7] alusrca [6:5] alusrcb [4:3] pcsrc [2:0] alucontrol
    logic [16:0] act;
    assign act = {trap, pcen, iord, memread, memwrite, irwrite, regdst,
                  memtoreg, regwrite, alusrca, alusrcb, pcsrc, alucontrol};

    // Expected word = {dc, act layout}; dc masks the ALU mux/control
    // fields in states where the ALU is unused.
    function automatic logic [17:0] mk(
        input logic dc, tr, pc, io, mr, mw, ir, rd, mt, rw, sa,
        input logic [1:0] sb, ps, input logic [2:0] ac);
        return {dc, tr, pc, io, mr, mw, ir, rd, mt, rw, sa, sb, ps, ac};
    endfunction

    task automatic check(input string nm, input logic [17:0] e);
        logic [16:0] m;
        m = e[17] ? 17'h1FF18 : 17'h1FFFF;
        vectors++;
        if ((act & m) !== (e[16:0] & m)) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (mask %h)",
                     nm, act & m, e[16:0] & m, m);
        end
    endtask

    task automatic check1(input string nm, input logic a, input logic e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    typedef struct {
        string       nm;
        logic [17:0] e;
    } sb_t;

    sb_t sbq[$];

    always @(negedge clk) begin
        sb_t s;
        #2;
        if (sbq.size() != 0) begin
            s = sbq.pop_front();
            check(s.nm, s.e);
        end
    end

    task automatic step(input string nm, input logic mr, input logic z,
                        input logic [5:0] o, input logic [5:0] f,
                        input logic [17:0] e);
        sb_t s;
        @(negedge clk);
        mem_ready = mr;
        zero      = z;
        op        = o;
        funct     = f;
        s.nm      = nm;
        s.e       = e;
        sbq.push_back(s);
    endtask

    typedef struct {
        string            nm;
        logic [5:0]       op;
        logic [5:0]       funct;
        logic             zero;
        int               n;
        logic [4:0][17:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input int n,
                       input logic [17:0] e0, e1, e2, e3, e4);
        vec_t v;
        v.nm     = nm;
        v.op     = o;
        v.funct  = f;
        v.zero   = z;
        v.n      = n;
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        v.exp[4] = e4;
        tbl.push_back(v);
    endtask

    logic [17:0] W_FETCH, W_FWAIT, W_DEC, W_MADR, W_MRD, W_MWR, W_MWB;
    logic [17:0] W_AWB, W_IWB, W_JMP, W_HALT, W_ADDI, W_RBAD, W_NONE;

    function automatic logic [17:0] w_rt(input logic [2:0] ac);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, ac);
    endfunction

    function automatic logic [17:0] w_logi(input logic [2:0] ac);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 2'b00, ac);
    endfunction

    function automatic logic [17:0] w_br(input logic pc);
        return mk(0, 0, pc, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110);
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        mem_ready   = 1'b0;
        zero        = 1'b0;
        op          = 6'b0;
        funct       = 6'b0;

        //             dc tr pc io mr mw ir rd mt rw sa  sb     ps     ac
        W_FETCH = mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
        W_FWAIT = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
        W_DEC   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
        W_MADR  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010);
        W_ADDI  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010);
        W_MRD   = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000);
        W_MWR   = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000);
        W_MWB   = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000);
        W_AWB   = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000);
        W_IWB   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000);
        W_JMP   = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000);
        W_HALT  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000);
        W_RBAD  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000);
        W_NONE  = '0;

        add("lw",   6'b100011, 6'b0, 0, 5, W_FETCH, W_DEC, W_MADR, W_MRD, W_MWB);
        add("sw",   6'b101011, 6'b0, 0, 4, W_FETCH, W_DEC, W_MADR, W_MWR, W_NONE);
        add("add",  6'b000000, 6'b100000, 0, 4, W_FETCH, W_DEC, w_rt(3'b010), W_AWB, W_NONE);
        add("sub",  6'b000000, 6'b100010, 0, 4, W_FETCH, W_DEC, w_rt(3'b110), W_AWB, W_NONE);
        add("and",  6'b000000, 6'b100100, 0, 4, W_FETCH, W_DEC, w_rt(3'b000), W_AWB, W_NONE);
        add("or",   6'b000000, 6'b100101, 0, 4, W_FETCH, W_DEC, w_rt(3'b001), W_AWB, W_NONE);
        add("slt",  6'b000000, 6'b101010, 0, 4, W_FETCH, W_DEC, w_rt(3'b111), W_AWB, W_NONE);
        add("addi", 6'b001000, 6'b0, 0, 4, W_FETCH, W_DEC, W_ADDI, W_IWB, W_NONE);
        add("andi", 6'b001100, 6'b0, 0, 4, W_FETCH, W_DEC, w_logi(3'b000), W_IWB, W_NONE);
        add("ori",  6'b001101, 6'b0, 0, 4, W_FETCH, W_DEC, w_logi(3'b001), W_IWB, W_NONE);
        add("beq_z1", 6'b000100, 6'b0, 1, 3, W_FETCH, W_DEC, w_br(1), W_NONE, W_NONE);
        add("beq_z0", 6'b000100, 6'b0, 0, 3, W_FETCH, W_DEC, w_br(0), W_NONE, W_NONE);
        add("bne_z0", 6'b000101, 6'b0, 0, 3, W_FETCH, W_DEC, w_br(1), W_NONE, W_NONE);
        add("bne_z1", 6'b000101, 6'b0, 1, 3, W_FETCH, W_DEC, w_br(0), W_NONE, W_NONE);
        add("j",    6'b000010, 6'b0, 0, 3, W_FETCH, W_DEC, W_JMP, W_NONE, W_NONE);

        #3;
        check("reset_state", W_FWAIT);
        check1("reset_nb_trap", nb_trap, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++)
                step($sformatf("%s_c%0d", tbl[i].nm, k + 1), 1'b1,
                     tbl[i].zero, tbl[i].op, tbl[i].funct, tbl[i].exp[k]);
        end
        #3;
        check1("nb_bne_trap", nb_trap, 1'b1);
        check1("nb_bne_halt_memread", nb_memread, 1'b0);

        // sw with three wait cycles in MEMWR
        step("sww_fetch", 1, 0, 6'b101011, 6'b0, W_FETCH);
        step("sww_dec",   1, 0, 6'b101011, 6'b0, W_DEC);
        step("sww_madr",  1, 0, 6'b101011, 6'b0, W_MADR);
        for (int k = 0; k < 3; k++)
            step($sformatf("sww_wait%0d", k), 0, 0, 6'b101011, 6'b0, W_MWR);
        step("sww_done",  1, 0, 6'b101011, 6'b0, W_MWR);

        // lw with a fetch stall and a MEMRD stall
        step("lww_fwait", 0, 0, 6'b100011, 6'b0, W_FWAIT);
        step("lww_fetch", 1, 0, 6'b100011, 6'b0, W_FETCH);
        step("lww_dec",   1, 0, 6'b100011, 6'b0, W_DEC);
        step("lww_madr",  1, 0, 6'b100011, 6'b0, W_MADR);
        step("lww_wait",  0, 0, 6'b100011, 6'b0, W_MRD);
        step("lww_rd",    1, 0, 6'b100011, 6'b0, W_MRD);
        step("lww_wb",    1, 0, 6'b100011, 6'b0, W_MWB);

        // async reset while MEMRD is stalled
        step("rst_fetch", 1, 0, 6'b100011, 6'b0, W_FETCH);
        step("rst_dec",   1, 0, 6'b100011, 6'b0, W_DEC);
        step("rst_madr",  1, 0, 6'b100011, 6'b0, W_MADR);
        step("rst_wait0", 0, 0, 6'b100011, 6'b0, W_MRD);
        step("rst_wait1", 0, 0, 6'b100011, 6'b0, W_MRD);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_mid_memrd", W_FWAIT);
        @(negedge clk);
        reset_n = 1'b1;

        // illegal funct traps into HALT, which holds until reset
        step("bad_fetch", 1, 0, 6'b000000, 6'b000111, W_FETCH);
        step("bad_dec",   1, 0, 6'b000000, 6'b000111, W_DEC);
        step("bad_rtex",  1, 0, 6'b000000, 6'b000111, W_RBAD);
        for (int k = 0; k < 10; k++)
            step($sformatf("halt%0d", k), 1, 0, 6'b100011, 6'b0, W_HALT);
        #3;
        mem_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("reset_clears_trap", W_FWAIT);
        @(negedge clk);
        reset_n = 1'b1;

        step("post_fetch", 1, 0, 6'b000010, 6'b0, W_FETCH);
        step("post_dec",   1, 0, 6'b000010, 6'b0, W_DEC);
        step("post_jump",  1, 0, 6'b000010, 6'b0, W_JMP);

        repeat (2) @(negedge clk);
        #3;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
